// File: rtl/rle_expand.sv
// Run-length expander: turns the rle_enc word stream (value words and
// flagged count words) back into one output word per original sample.
// A count word C repeats the most recent value C more times. With enable
// low every word is forwarded unchanged.
module rle_expand #(
   parameter int DW = 32,
   parameter int KW = DW / 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [KW-1:0] disabledGroups,
   input  logic [DW-1:0] sti_data,
   input  logic          sti_valid,
   output logic          sti_ready,
   output logic [DW-1:0] sto_data,
   output logic          sto_valid,
   input  logic          sto_ready,
   output logic          err
);

   localparam logic [KW-1:0] MODE8  = {{(KW-1){1'b1}}, 1'b0};
   localparam logic [KW-1:0] MODE16 = {{(KW-2){1'b1}}, 2'b00};

   typedef enum logic {IDLE, REPEAT} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] last_value;
   logic          have_value;
   logic [DW-2:0] run_cnt;
   logic [DW-1:0] mask;
   logic [DW-1:0] payload;
   logic          flag;
   logic          slot_free;
   logic          accept;
   logic          run_start;

   // Flag position and payload mask follow the active byte-group mode
   always_comb begin
      mask = {1'b0, {(DW-1){1'b1}}};
      flag = sti_data[DW-1];
      if (disabledGroups == MODE8) begin
         mask = DW'(8'h7F);
         flag = sti_data[7];
      end else if (disabledGroups == MODE16) begin
         mask = DW'(16'h7FFF);
         flag = sti_data[15];
      end
      payload = sti_data & mask;
   end

   // The output slot can take a new word when empty or draining this cycle
   assign slot_free = !sto_valid || sto_ready;
   assign sti_ready = !rst && (state == IDLE) && slot_free;
   assign accept    = sti_valid && sti_ready;
   assign run_start = accept && enable && flag && (payload[DW-2:0] != '0) && have_value;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: enter REPEAT on a usable count word, leave after the last copy
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (run_start) state_nxt = REPEAT;
         REPEAT:  if (slot_free && run_cnt == DW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output slot, remembered value, run counter and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         sto_data   <= '0;
         sto_valid  <= 1'b0;
         last_value <= '0;
         have_value <= 1'b0;
         run_cnt    <= '0;
         err        <= 1'b0;
      end else begin
         if (slot_free) sto_valid <= 1'b0;
         if (state == REPEAT) begin
            if (slot_free) begin
               sto_data  <= last_value;
               sto_valid <= 1'b1;
               run_cnt   <= run_cnt - 1'b1;
            end
         end else if (accept) begin
            if (!enable) begin
               sto_data  <= sti_data;
               sto_valid <= 1'b1;
               if (!flag) begin
                  last_value <= payload;
                  have_value <= 1'b1;
               end
            end else if (!flag) begin
               sto_data   <= payload;
               sto_valid  <= 1'b1;
               last_value <= payload;
               have_value <= 1'b1;
            end else if (payload[DW-2:0] != '0) begin
               if (have_value) run_cnt <= payload[DW-2:0];
               else            err     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rle_expand.sv
// Scoreboard bench for rle_expand: the driver pushes expected words computed
// from the stream-level expansion rules; a monitor pops on every transfer.
module tb_rle_expand;
   localparam int DW = 32;
   localparam int KW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [KW-1:0] dg;
   logic [DW-1:0] sti_data;
   logic          sti_valid;
   logic          sti_ready;
   logic [DW-1:0] sto_data;
   logic          sto_valid;
   logic          sto_ready;
   logic          err;

   rle_expand #(.DW(DW), .KW(KW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .disabledGroups(dg),
      .sti_data(sti_data), .sti_valid(sti_valid), .sti_ready(sti_ready),
      .sto_data(sto_data), .sto_valid(sto_valid), .sto_ready(sto_ready),
      .err(err)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] exp_q[$];
   int            out_cyc[$];
   int            out_cnt = 0;
   int            acc_cyc = 0;
   bit            rand_rdy = 0;
   bit            m_have = 0, m_err = 0;
   logic [DW-1:0] m_last = '0;

   task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int fpos(logic [KW-1:0] m);
      if (m == 4'b1110) return 7;
      if (m == 4'b1100) return 15;
      return 31;
   endfunction

   // Reference: what one accepted word contributes to the output stream
   task automatic model(logic [DW-1:0] w, bit en);
      int fp = fpos(dg);
      logic [DW-1:0] msk = (DW'(1) << fp) - DW'(1);
      logic [DW-1:0] pl  = w & msk;
      bit fl = w[fp];
      if (!en) begin
         exp_q.push_back(w);
         if (!fl) begin m_last = pl; m_have = 1; end
      end else if (!fl) begin
         exp_q.push_back(pl);
         m_last = pl; m_have = 1;
      end else if (pl != 0) begin
         if (!m_have) m_err = 1;
         else for (int i = 0; i < int'(pl); i++) exp_q.push_back(m_last);
      end
   endtask

   // Monitor: every transfer must match the head of the expected queue
   initial forever begin
      @(negedge clk);
      if (!rst && sto_valid && sto_ready) begin
         out_cnt++;
         out_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: got %h expected none", sto_data);
         end else check("sto_data", sto_data, exp_q.pop_front());
      end
   end

   // Downstream ready: constant 1 or pseudo-random
   initial begin
      sto_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         sto_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(logic [DW-1:0] w, bit en);
      int t = 0;
      enable = en; sti_data = w; sti_valid = 1'b1;
      @(negedge clk);
      while (!sti_ready && t < 2000) begin @(negedge clk); t++; end
      if (!sti_ready) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: got ready=0 expected ready=1");
      end else begin
         acc_cyc = cyc + 1;
         model(w, en);
      end
      @(posedge clk); #1;
      sti_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); t++; end
      repeat (4) @(posedge clk);
      #1;
      check("drain_left", exp_q.size(), 0);
      check("err", err, m_err);
   endtask

   // Called #1 after a posedge; checks the reset state one edge later
   task automatic do_reset();
      rst = 1'b1; sti_valid = 1'b0;
      exp_q.delete(); out_cyc.delete();
      m_have = 0; m_err = 0; m_last = '0;
      @(negedge clk);
      check("rst_sti_ready", sti_ready, 0);
      @(negedge clk);
      check("rst_sto_valid", sto_valid, 0);
      check("rst_sto_data", sto_data, 0);
      check("rst_err", err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int a, c0, t;
      rst = 1'b1; enable = 1'b1; dg = 4'b1110; sti_data = '0; sti_valid = 1'b0;
      @(posedge clk); #1;

      // single value word, 8-bit mode
      do_reset();
      send(32'h41, 1); a = acc_cyc;
      drain();
      check("t1_count", out_cyc.size(), 1);
      if (out_cyc.size() >= 1) check("t1_latency", out_cyc[0], a);

      // value then count 3
      do_reset();
      send(32'h43, 1);
      send(32'h83, 1); a = acc_cyc;
      drain();
      check("t2_count", out_cyc.size(), 4);
      if (out_cyc.size() == 4) begin
         check("t2_first_copy", out_cyc[1], a + 1);
         check("t2_last_copy", out_cyc[3], a + 3);
      end

      // 16-bit mode, C=300
      dg = 4'b1100;
      do_reset();
      c0 = out_cnt;
      send(32'h1234, 1);
      send(32'h812C, 1);
      drain();
      check("t3_count", out_cnt - c0, 301);

      // 32-bit mode with random backpressure
      dg = 4'b0000;
      do_reset();
      rand_rdy = 1; c0 = out_cnt;
      send(32'h05, 1);
      send(32'h8000_0002, 1);
      drain();
      rand_rdy = 0;
      check("t4_count", out_cnt - c0, 3);

      // count before any value: error, sticky
      dg = 4'b1110;
      do_reset();
      c0 = out_cnt;
      send(32'h87, 1);
      drain();
      check("t5_no_output", out_cnt - c0, 0);
      send(32'h10, 1);
      drain();
      check("t5_one_output", out_cnt - c0, 1);

      // pass-through
      do_reset();
      c0 = out_cnt;
      send(32'h85, 0);
      send(32'h22, 0);
      drain();
      check("t6_count", out_cnt - c0, 2);

      // reset in the middle of a long run
      do_reset();
      c0 = out_cnt; t = 0;
      send(32'h43, 1);
      send(32'hFF, 1);
      while (out_cnt - c0 < 11 && t < 500) begin @(posedge clk); t++; end
      #1;
      check("t7_reached", (out_cnt - c0) >= 11, 1);
      do_reset();
      c0 = out_cnt;
      repeat (20) @(posedge clk);
      #1;
      check("t7_no_more", out_cnt - c0, 0);
      send(32'h81, 1);
      drain();
      check("t7_err_after_rst", err, 1);

      // randomized segments
      for (int s = 0; s < 8; s++) begin
         int md = $urandom_range(0, 2);
         dg = (md == 0) ? 4'b1110 : (md == 1) ? 4'b1100 : 4'b0000;
         do_reset();
         rand_rdy = $urandom_range(0, 1);
         for (int k = 0; k < 40; k++) begin
            int fp = fpos(dg);
            int r = $urandom_range(0, 9);
            bit en = ($urandom_range(0, 4) != 0);
            logic [DW-1:0] msk = (DW'(1) << fp) - DW'(1);
            logic [DW-1:0] w;
            if (r < 5)      w = $urandom & msk;
            else if (r < 8) w = (DW'(1) << fp) | DW'($urandom_range(0, 4));
            else begin
               w = $urandom; en = 0;
            end
            send(w, en);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
         drain();
         rand_rdy = 0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
